// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants, writeback payload type and register decode helper.
package regfile_wb_arbiter_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned PC_REG = 15;
    localparam int unsigned N_REG  = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // One-hot decode of a register address into a per-register mask.
    function automatic logic [N_REG-1:0] reg_decode(input logic [ADDR_W-1:0] a);
        reg_decode = N_REG'(1) << a;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after i_ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N     = 3,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant_c,
    output logic             o_valid_c
);

    // Walk search distances in order; the first requester at the current distance wins.
    always_comb begin
        o_grant_c = '0;
        o_valid_c = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            for (int unsigned j = 0; j < N; j++) begin
                if (!o_valid_c && i_req[j] &&
                    (((j >= 32'(i_ptr)) ? (j - 32'(i_ptr)) : (j + N - 32'(i_ptr))) == k)) begin
                    o_grant_c[j] = 1'b1;
                    o_valid_c    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port among N_REQ writeback requesters.
// One-entry buffer per requester, round-robin grant, registered write outputs,
// R15 writes diverted to the PC load path, pending-destination mask for decode.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic                      wb_hold,
    input  logic                      flush,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_a3,
    output logic [DATA_W-1:0]         rf_wd3,
    output logic                      pc_we,
    output logic [DATA_W-1:0]         pc_wd,
    output logic [N_REG-1:0]          pend_mask
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]  r_full;
    wb_req_t           r_slot [N_REQ];
    logic [PTR_W-1:0]  r_ptr;
    logic              r_rf_we;
    logic [ADDR_W-1:0] r_rf_a3;
    logic [DATA_W-1:0] r_rf_wd3;
    logic              r_pc_we;
    logic [DATA_W-1:0] r_pc_wd;

    logic [N_REQ-1:0]  w_arb_req;
    logic [N_REQ-1:0]  w_grant;
    logic              w_gvalid;
    logic [N_REQ-1:0]  w_accept;
    wb_req_t           w_sel;
    logic [PTR_W-1:0]  w_next_ptr;
    logic [N_REG-1:0]  w_pend;

    // Hold and flush both suppress arbitration for this cycle.
    assign w_arb_req = r_full & {N_REQ{~wb_hold & ~flush}};

    rr_arbiter #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .i_req     (w_arb_req),
        .i_ptr     (r_ptr),
        .o_grant_c (w_grant),
        .o_valid_c (w_gvalid)
    );

    // A slot can take a new entry when empty or when it is being drained this cycle.
    assign req_ready = ~{N_REQ{flush}} & (~r_full | w_grant);
    assign w_accept  = req_valid & req_ready;

    // Select the granted payload and the pointer that follows it.
    always_comb begin
        w_sel      = '0;
        w_next_ptr = r_ptr;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (w_grant[j]) begin
                w_sel      = r_slot[j];
                w_next_ptr = (j == N_REQ - 1) ? '0 : PTR_W'(j + 1);
            end
        end
    end

    // Slot buffers: flush empties, accept refills, grant drains.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full <= '0;
            for (int unsigned j = 0; j < N_REQ; j++) begin
                r_slot[j] <= '0;
            end
        end else if (flush) begin
            r_full <= '0;
        end else begin
            for (int unsigned j = 0; j < N_REQ; j++) begin
                if (w_accept[j]) begin
                    r_full[j]      <= 1'b1;
                    r_slot[j].addr <= req_addr[j*ADDR_W +: ADDR_W];
                    r_slot[j].data <= req_data[j*DATA_W +: DATA_W];
                end else if (w_grant[j]) begin
                    r_full[j] <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointer advances past the last granted requester.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (w_gvalid) begin
            r_ptr <= w_next_ptr;
        end
    end

    // Registered write outputs; R15 goes to the PC path instead of the register file.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rf_we  <= 1'b0;
            r_rf_a3  <= '0;
            r_rf_wd3 <= '0;
            r_pc_we  <= 1'b0;
            r_pc_wd  <= '0;
        end else if (w_gvalid) begin
            if (w_sel.addr == ADDR_W'(PC_REG)) begin
                r_rf_we <= 1'b0;
                r_pc_we <= 1'b1;
                r_pc_wd <= w_sel.data;
            end else begin
                r_rf_we  <= 1'b1;
                r_rf_a3  <= w_sel.addr;
                r_rf_wd3 <= w_sel.data;
                r_pc_we  <= 1'b0;
            end
        end else begin
            r_rf_we <= 1'b0;
            r_pc_we <= 1'b0;
        end
    end

    // Pending destinations: buffered slots plus whatever is on the output this cycle.
    always_comb begin
        w_pend = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (r_full[j]) begin
                w_pend = w_pend | reg_decode(r_slot[j].addr);
            end
        end
        if (r_rf_we) begin
            w_pend = w_pend | reg_decode(r_rf_a3);
        end
        if (r_pc_we) begin
            w_pend = w_pend | reg_decode(ADDR_W'(PC_REG));
        end
    end

    assign rf_we     = r_rf_we;
    assign rf_a3     = r_rf_a3;
    assign rf_wd3    = r_rf_wd3;
    assign pc_we     = r_pc_we;
    assign pc_wd     = r_pc_wd;
    assign pend_mask = w_pend;

endmodule
